// File: rtl/clint.sv
// clint: core-local interruptor for a single-hart core.
//
// Owns the memory-mapped msip, mtimecmp and mtime registers, free-runs the
// 64-bit mtime counter from a prescaled core clock and drives the registered
// software/timer interrupt lines.
//
// Parameters:
//   clock_rate   core clock cycles per mtime tick (1..2^16)
// Ports:
//   clock        core clock, all state on the rising edge
//   reset        synchronous active-high reset
//   clint_valid  bus request strobe, one request per high cycle
//   clint_instr  instruction fetch flag (fetches read as data)
//   clint_addr   byte address, only [15:2] decoded
//   clint_wdata  write data
//   clint_wstrb  byte enables, 0 means read
//   clint_rdata  read data, valid with clint_ready, else 0
//   clint_ready  one-cycle response strobe, one cycle after the request
//   clint_msip   machine software interrupt pending
//   clint_mtip   machine timer interrupt pending
//   clint_mtime  current mtime value
module clint #(
    parameter int unsigned clock_rate = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clint_valid,
    input  logic        clint_instr,
    input  logic [31:0] clint_addr,
    input  logic [31:0] clint_wdata,
    input  logic [3:0]  clint_wstrb,
    output logic [31:0] clint_rdata,
    output logic        clint_ready,
    output logic        clint_msip,
    output logic        clint_mtip,
    output logic [63:0] clint_mtime
);

    // 17 bits covers clock_rate up to 2^16 (terminal count 2^16-1).
    localparam logic [16:0] tick_max = 17'(clock_rate - 1);

    // Word offsets (addr[15:2]) of the mapped registers.
    localparam logic [13:0] off_msip     = 14'h0000;
    localparam logic [13:0] off_cmp_lo   = 14'h1000;
    localparam logic [13:0] off_cmp_hi   = 14'h1001;
    localparam logic [13:0] off_mtime_lo = 14'h2FFE;
    localparam logic [13:0] off_mtime_hi = 14'h2FFF;

    logic [16:0] tick_cnt, tick_cnt_next;
    logic [63:0] mtime, mtime_next;
    logic [63:0] mtimecmp, mtimecmp_next;
    logic        msip, msip_next;
    logic        mtip;
    logic        ready;
    logic [31:0] rdata, rdata_next;

    logic [13:0] word_off;
    logic        wr;
    logic        tick;
    logic [63:0] mtime_inc;

    // Address bits outside the decoded window are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{clint_addr[31:16], clint_addr[1:0]};

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] r;
        r = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) r[8*i +: 8] = new_val[8*i +: 8];
        end
        return r;
    endfunction

    assign word_off  = clint_addr[15:2];
    assign wr        = clint_valid && !clint_instr && (clint_wstrb != 4'b0000);
    assign tick      = (tick_cnt == tick_max);
    assign mtime_inc = mtime + 64'd1;

    always_comb begin
        tick_cnt_next = tick ? 17'd0 : tick_cnt + 17'd1;
        mtime_next    = tick ? mtime_inc : mtime;
        mtimecmp_next = mtimecmp;
        msip_next     = msip;

        if (wr) begin
            case (word_off)
                off_msip: begin
                    if (clint_wstrb[0]) msip_next = clint_wdata[0];
                end
                off_cmp_lo: begin
                    mtimecmp_next[31:0] = merge_bytes(mtimecmp[31:0], clint_wdata, clint_wstrb);
                end
                off_cmp_hi: begin
                    mtimecmp_next[63:32] = merge_bytes(mtimecmp[63:32], clint_wdata, clint_wstrb);
                end
                // A write to one mtime half suppresses the tick for the whole
                // counter this cycle, so no carry leaks into the other half.
                off_mtime_lo: begin
                    mtime_next = {mtime[63:32], merge_bytes(mtime[31:0], clint_wdata, clint_wstrb)};
                end
                off_mtime_hi: begin
                    mtime_next = {merge_bytes(mtime[63:32], clint_wdata, clint_wstrb), mtime[31:0]};
                end
                default: ;
            endcase
        end
    end

    // Read data reflects the state as it will be after this cycle's update.
    always_comb begin
        rdata_next = 32'd0;
        if (clint_valid) begin
            case (word_off)
                off_msip:     rdata_next = {31'd0, msip_next};
                off_cmp_lo:   rdata_next = mtimecmp_next[31:0];
                off_cmp_hi:   rdata_next = mtimecmp_next[63:32];
                off_mtime_lo: rdata_next = mtime_next[31:0];
                off_mtime_hi: rdata_next = mtime_next[63:32];
                default:      rdata_next = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tick_cnt <= 17'd0;
            mtime    <= 64'd0;
            mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
            msip     <= 1'b0;
            mtip     <= 1'b0;
            ready    <= 1'b0;
            rdata    <= 32'd0;
        end else begin
            tick_cnt <= tick_cnt_next;
            mtime    <= mtime_next;
            mtimecmp <= mtimecmp_next;
            msip     <= msip_next;
            // Compare uses pre-update values: a register write shows on mtip
            // two cycles later.
            mtip     <= (mtime >= mtimecmp);
            ready    <= clint_valid;
            rdata    <= rdata_next;
        end
    end

    assign clint_rdata = rdata;
    assign clint_ready = ready;
    assign clint_msip  = msip;
    assign clint_mtip  = mtip;
    assign clint_mtime = mtime;

endmodule

// File: tb/tb_clint.sv
// tb_clint: directed self-checking bench for clint.
// Instance a uses clock_rate=10 (prescaler checks); instance b uses
// clock_rate=1 for the bus, timer and interrupt checks. Inputs are shared.
module tb_clint;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        clint_valid = 1'b0;
    logic        clint_instr = 1'b0;
    logic [31:0] clint_addr = 32'd0;
    logic [31:0] clint_wdata = 32'd0;
    logic [3:0]  clint_wstrb = 4'd0;

    logic [31:0] a_rdata, b_rdata;
    logic        a_ready, b_ready;
    logic        a_msip, b_msip;
    logic        a_mtip, b_mtip;
    logic [63:0] a_mtime, b_mtime;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clock = ~clock;

    clint #(.clock_rate(10)) u_a (
        .clock       (clock),
        .reset       (reset),
        .clint_valid (clint_valid),
        .clint_instr (clint_instr),
        .clint_addr  (clint_addr),
        .clint_wdata (clint_wdata),
        .clint_wstrb (clint_wstrb),
        .clint_rdata (a_rdata),
        .clint_ready (a_ready),
        .clint_msip  (a_msip),
        .clint_mtip  (a_mtip),
        .clint_mtime (a_mtime)
    );

    clint #(.clock_rate(1)) u_b (
        .clock       (clock),
        .reset       (reset),
        .clint_valid (clint_valid),
        .clint_instr (clint_instr),
        .clint_addr  (clint_addr),
        .clint_wdata (clint_wdata),
        .clint_wstrb (clint_wstrb),
        .clint_rdata (b_rdata),
        .clint_ready (b_ready),
        .clint_msip  (b_msip),
        .clint_mtip  (b_mtip),
        .clint_mtime (b_mtime)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one request in the current cycle; returns at the negedge of the
    // response cycle with valid already dropped (a following call keeps the
    // requests back-to-back).
    task automatic req(input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb);
        clint_valid = 1'b1;
        clint_addr  = addr;
        clint_wdata = wdata;
        clint_wstrb = strb;
        @(negedge clock);
        clint_valid = 1'b0;
        clint_wstrb = 4'd0;
    endtask

    initial begin
        bit found;

        // Reset held for 3 cycles.
        repeat (3) @(negedge clock);
        check("rst_mtime_a", a_mtime, 64'd0);
        check("rst_mtime_b", b_mtime, 64'd0);
        check("rst_mtip", {63'd0, b_mtip}, 64'd0);
        check("rst_msip", {63'd0, b_msip}, 64'd0);
        check("rst_ready", {63'd0, b_ready}, 64'd0);
        check("rst_rdata", {32'd0, b_rdata}, 64'd0);
        reset = 1'b0;

        // Prescaler, clock_rate=10.
        repeat (9) @(negedge clock);
        check("presc_9", a_mtime, 64'd0);
        @(negedge clock);
        check("presc_10", a_mtime, 64'd1);
        repeat (40) @(negedge clock);
        check("presc_50", a_mtime, 64'd5);

        // mtimecmp reset value readback.
        req(32'h4000, 32'd0, 4'h0);
        check("cmp_lo_rst", {32'd0, b_rdata}, 64'hFFFF_FFFF);
        req(32'h4004, 32'd0, 4'h0);
        check("cmp_hi_rst", {32'd0, b_rdata}, 64'hFFFF_FFFF);

        // Timer interrupt, clock_rate=1.
        req(32'hBFF8, 32'd0, 4'hF);
        req(32'h4004, 32'd0, 4'hF);
        req(32'h4000, 32'd20, 4'hF);
        check("mtip_before", {63'd0, b_mtip}, 64'd0);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (b_mtime == 64'd20) found = 1'b1;
            else @(negedge clock);
        end
        check("mtime_reach20", {63'd0, found}, 64'd1);
        check("mtip_at20", {63'd0, b_mtip}, 64'd0);
        @(negedge clock);
        check("mtip_rise", {63'd0, b_mtip}, 64'd1);
        req(32'h4004, 32'hFFFF_FFFF, 4'hF);
        check("mtip_hold", {63'd0, b_mtip}, 64'd1);
        @(negedge clock);
        check("mtip_fall", {63'd0, b_mtip}, 64'd0);

        // Software interrupt.
        req(32'h0000, 32'hFFFF_FFFF, 4'hF);
        check("msip_set", {63'd0, b_msip}, 64'd1);
        req(32'h0000, 32'd0, 4'h0);
        check("msip_rd", {32'd0, b_rdata}, 64'd1);
        check("msip_keep", {63'd0, b_msip}, 64'd1);
        req(32'h0000, 32'd0, 4'hF);
        check("msip_clr", {63'd0, b_msip}, 64'd0);

        // Byte strobes.
        req(32'h4000, 32'hFFFF_FFFF, 4'hF);
        req(32'h4000, 32'hAABB_CCDD, 4'h2);
        req(32'h4000, 32'd0, 4'h0);
        check("strb_rd", {32'd0, b_rdata}, 64'hFFFF_CCFF);

        // Wrap.
        req(32'hBFFC, 32'hFFFF_FFFF, 4'hF);
        req(32'hBFF8, 32'hFFFF_FFFE, 4'hF);
        check("wrap_fe", b_mtime, 64'hFFFF_FFFF_FFFF_FFFE);
        @(negedge clock);
        check("wrap_ff", b_mtime, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clock);
        check("wrap_0", b_mtime, 64'd0);

        // Same-cycle mtime write and tick: written value wins, no tick on the
        // other half.
        req(32'hBFF8, 32'h100, 4'hF);
        check("wr_tick_lo", b_mtime, 64'h100);
        req(32'hBFFC, 32'd5, 4'hF);
        check("wr_tick_hi", b_mtime, 64'h0000_0005_0000_0100);
        @(negedge clock);
        check("wr_tick_run", b_mtime, 64'h0000_0005_0000_0101);

        // Four back-to-back requests.
        req(32'h0000, 32'd1, 4'hF);
        check("b2b_rdy0", {63'd0, b_ready}, 64'd1);
        req(32'h1234, 32'd0, 4'h0);
        check("b2b_rdy1", {63'd0, b_ready}, 64'd1);
        check("unmapped_rd", {32'd0, b_rdata}, 64'd0);
        req(32'h4004, 32'h1234_5678, 4'hF);
        check("b2b_rdy2", {63'd0, b_ready}, 64'd1);
        req(32'h4004, 32'd0, 4'h0);
        check("b2b_rdy3", {63'd0, b_ready}, 64'd1);
        check("b2b_rd3", {32'd0, b_rdata}, 64'h1234_5678);
        @(negedge clock);
        check("idle_ready", {63'd0, b_ready}, 64'd0);
        check("idle_rdata", {32'd0, b_rdata}, 64'd0);
        check("b2b_msip", {63'd0, b_msip}, 64'd1);

        // Reset during a request drops it.
        clint_valid = 1'b1;
        clint_addr  = 32'h0000;
        reset = 1'b1;
        @(negedge clock);
        clint_valid = 1'b0;
        reset = 1'b0;
        check("rstreq_ready0", {63'd0, b_ready}, 64'd0);
        check("rstreq_msip", {63'd0, b_msip}, 64'd0);
        @(negedge clock);
        check("rstreq_ready1", {63'd0, b_ready}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
